pkt_sf_fifo: RTL and testbench

PKT_SF_FIFO -- requirements
Module: pkt_sf_fifo

---
 rtl/eth_pkg.sv | 15 +
 rtl/pkt_sf_ram.sv | 23 ++
 rtl/pkt_sf_fifo.sv | 227 ++++++++++++++++++++++
 tb/tb_pkt_sf_fifo.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared constants and pointer helpers for the packet store-and-forward FIFO.
package eth_pkg;

  localparam int DATA_BYTES_DEF  = 1;
  localparam int DEPTH_WORDS_DEF = 2048;
  localparam int MAX_PKTS_DEF    = 16;

  // Pointer width: one extra MSB beyond the address so full and empty differ.
  function automatic int ptr_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [ptr_bits(DEPTH_WORDS_DEF)-1:0] ptr_def_t;

endpackage

// File: rtl/pkt_sf_ram.sv
// Simple dual-port single-clock RAM with a registered (1-cycle) read port.
module pkt_sf_ram #(
  parameter int WIDTH  = 10,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/pkt_sf_fifo.sv
// AXI-Stream packet store-and-forward FIFO with a 2-entry output skid buffer.
// Define ETH_PKT_FIFO_DROP_EN to drop errored (tuser) and oversize packets.
module pkt_sf_fifo
  import eth_pkg::*;
#(
  parameter int DATA_BYTES  = DATA_BYTES_DEF,
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int MAX_PKTS    = MAX_PKTS_DEF
) (
  input  logic                          clk_axi,
  input  logic                          rst_axi,
  input  logic                          clear_i,
  input  logic [8*DATA_BYTES-1:0]       s_tdata,
  input  logic [DATA_BYTES-1:0]         s_tkeep,
  input  logic                          s_tvalid,
  input  logic                          s_tlast,
  input  logic                          s_tuser,
  output logic                          s_tready,
  output logic [8*DATA_BYTES-1:0]       m_tdata,
  output logic [DATA_BYTES-1:0]         m_tkeep,
  output logic                          m_tvalid,
  output logic                          m_tlast,
  input  logic                          m_tready,
  output logic [$clog2(MAX_PKTS):0]     pkt_cnt,
  output logic [$clog2(DEPTH_WORDS):0]  free_words,
  output logic                          drop_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = ptr_bits(DEPTH_WORDS);
  localparam int CW = $clog2(MAX_PKTS) + 1;
  localparam int RW = 9*DATA_BYTES + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam ptr_t PTR_ONE = ptr_t'(1);
  localparam ptr_t DEPTH_P = ptr_t'(DEPTH_WORDS);
  localparam cnt_t CNT_ONE = cnt_t'(1);
  localparam cnt_t CNT_MAX = cnt_t'(MAX_PKTS);

  ptr_t          wr_ptr_q, wr_ptr_d, wr_cmt_q, wr_cmt_d, rd_ptr_q, rd_ptr_d;
  cnt_t          pkt_cnt_q, pkt_cnt_d;
  logic [RW-1:0] skid_q [2];
  logic [RW-1:0] skid_d [2];
  logic [1:0]    skid_cnt_q, skid_cnt_d;
  logic          rd_pend_q;
  logic [2:0]    occ_nxt;
  logic          ram_we, ram_re;
  logic [RW-1:0] ram_wdata, ram_rdata, head;
  logic          wr_full, pkt_full, s_fire, m_fire, commit, pop_last;

  assign wr_full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pkt_full  = (pkt_cnt_q == CNT_MAX);
  assign ram_wdata = {s_tlast, s_tkeep, s_tdata};

`ifdef ETH_PKT_FIFO_DROP_EN
  logic ovf_q, ovf_d, drop_q, drop_d;

  assign s_tready = rst_axi & ~clear_i & ~pkt_full;
  assign s_fire   = s_tvalid & s_tready;

  // Overflowing beats are swallowed; the packet is rewound at its tlast.
  always_comb begin
    ovf_d    = ovf_q;
    drop_d   = 1'b0;
    wr_ptr_d = wr_ptr_q;
    wr_cmt_d = wr_cmt_q;
    ram_we   = 1'b0;
    commit   = 1'b0;
    if (s_fire) begin
      if (s_tlast) begin
        ovf_d = 1'b0;
        if (ovf_q || wr_full || s_tuser) begin
          drop_d   = 1'b1;
          wr_ptr_d = wr_cmt_q;
        end else begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          wr_cmt_d = wr_ptr_q + PTR_ONE;
          commit   = 1'b1;
        end
      end else if (ovf_q || wr_full) begin
        ovf_d = 1'b1;
      end else begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk_axi or negedge rst_axi) begin
    if (!rst_axi) begin
      ovf_q  <= 1'b0;
      drop_q <= 1'b0;
    end else if (clear_i) begin
      ovf_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  assign drop_o = drop_q;
`else
  logic unused_tuser;

  assign unused_tuser = s_tuser;
  assign s_tready     = rst_axi & ~clear_i & ~pkt_full & ~wr_full;
  assign s_fire       = s_tvalid & s_tready;
  assign ram_we       = s_fire;

  // A packet larger than the RAM would deadlock; once the RAM holds nothing
  // but its uncommitted words, release them so the reader can make room.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    wr_cmt_d = wr_cmt_q;
    commit   = 1'b0;
    if (s_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (s_fire && s_tlast) begin
      wr_cmt_d = wr_ptr_q + PTR_ONE;
      commit   = 1'b1;
    end else if (wr_full && (wr_cmt_q == rd_ptr_q)) begin
      wr_cmt_d = wr_ptr_q;
    end
  end

  assign drop_o = 1'b0;
`endif

  // Head of the output is the skid buffer, or the RAM read port when it is empty.
  assign head     = (skid_cnt_q != 2'd0) ? skid_q[0] : ram_rdata;
  assign m_tvalid = ~clear_i & ((skid_cnt_q != 2'd0) | rd_pend_q);
  assign {m_tlast, m_tkeep, m_tdata} = m_tvalid ? head : '0;
  assign m_fire   = m_tvalid & m_tready;
  assign pop_last = m_fire & m_tlast;

  assign occ_nxt  = {1'b0, skid_cnt_q} + {2'b00, rd_pend_q} - {2'b00, m_fire};
  assign ram_re   = ~clear_i && (rd_ptr_q != wr_cmt_q) && (occ_nxt < 3'd2);
  assign rd_ptr_d = ram_re ? rd_ptr_q + PTR_ONE : rd_ptr_q;

  always_comb begin
    skid_d[0]  = skid_q[0];
    skid_d[1]  = skid_q[1];
    skid_cnt_d = skid_cnt_q;
    case (skid_cnt_q)
      2'd0: begin
        if (rd_pend_q && !m_fire) begin
          skid_d[0]  = ram_rdata;
          skid_cnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (m_fire) begin
          if (rd_pend_q) skid_d[0] = ram_rdata;
          else           skid_cnt_d = 2'd0;
        end else if (rd_pend_q) begin
          skid_d[1]  = ram_rdata;
          skid_cnt_d = 2'd2;
        end
      end
      default: begin
        if (m_fire) begin
          skid_d[0] = skid_q[1];
          if (rd_pend_q) skid_d[1] = ram_rdata;
          else           skid_cnt_d = 2'd1;
        end
      end
    endcase
  end

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (commit && !pop_last)      pkt_cnt_d = pkt_cnt_q + CNT_ONE;
    else if (!commit && pop_last) pkt_cnt_d = pkt_cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk_axi or negedge rst_axi) begin
    if (!rst_axi) begin
      wr_ptr_q   <= '0;
      wr_cmt_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      skid_q[0]  <= '0;
      skid_q[1]  <= '0;
      skid_cnt_q <= 2'd0;
      rd_pend_q  <= 1'b0;
    end else if (clear_i) begin
      wr_ptr_q   <= '0;
      wr_cmt_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      skid_q[0]  <= '0;
      skid_q[1]  <= '0;
      skid_cnt_q <= 2'd0;
      rd_pend_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      wr_cmt_q   <= wr_cmt_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      skid_q[0]  <= skid_d[0];
      skid_q[1]  <= skid_d[1];
      skid_cnt_q <= skid_cnt_d;
      rd_pend_q  <= ram_re;
    end
  end

  assign pkt_cnt    = pkt_cnt_q;
  assign free_words = DEPTH_P - (wr_cmt_q - rd_ptr_q);

  pkt_sf_ram #(
    .WIDTH  (RW),
    .DEPTH  (DEPTH_WORDS),
    .ADDR_W (AW)
  ) u_ram (
    .clk_i     (clk_axi),
    .wr_en_i   (ram_we),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_data_i (ram_wdata),
    .rd_en_i   (ram_re),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (ram_rdata)
  );

endmodule

// File: tb/tb_pkt_sf_fifo.sv
// Directed bench for pkt_sf_fifo: a 2048-word instance (idx 0) and a 16-word instance (idx 1).
module tb_pkt_sf_fifo;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      clr, s_tvalid, s_tlast, s_tuser, s_tready;
  logic [1:0]      m_tvalid, m_tlast, m_tready, drop;
  logic [1:0][7:0] s_tdata, m_tdata;
  logic [1:0][0:0] s_tkeep, m_tkeep;
  logic [1:0][4:0] pkt_cnt;
  logic [11:0]     free_big;
  logic [4:0]      free_small;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int drop_n [2];
  bit tv_seen [2];
  logic [9:0] rx_q0[$], rx_q1[$];
  int rx_cyc0[$];

  always #5 clk = ~clk;

  pkt_sf_fifo #(.DATA_BYTES(1)) u_big (
    .clk_axi(clk), .rst_axi(rst_n), .clear_i(clr[0]),
    .s_tdata(s_tdata[0]), .s_tkeep(s_tkeep[0]), .s_tvalid(s_tvalid[0]),
    .s_tlast(s_tlast[0]), .s_tuser(s_tuser[0]), .s_tready(s_tready[0]),
    .m_tdata(m_tdata[0]), .m_tkeep(m_tkeep[0]), .m_tvalid(m_tvalid[0]),
    .m_tlast(m_tlast[0]), .m_tready(m_tready[0]),
    .pkt_cnt(pkt_cnt[0]), .free_words(free_big), .drop_o(drop[0])
  );

  pkt_sf_fifo #(.DATA_BYTES(1), .DEPTH_WORDS(16)) u_small (
    .clk_axi(clk), .rst_axi(rst_n), .clear_i(clr[1]),
    .s_tdata(s_tdata[1]), .s_tkeep(s_tkeep[1]), .s_tvalid(s_tvalid[1]),
    .s_tlast(s_tlast[1]), .s_tuser(s_tuser[1]), .s_tready(s_tready[1]),
    .m_tdata(m_tdata[1]), .m_tkeep(m_tkeep[1]), .m_tvalid(m_tvalid[1]),
    .m_tlast(m_tlast[1]), .m_tready(m_tready[1]),
    .pkt_cnt(pkt_cnt[1]), .free_words(free_small), .drop_o(drop[1])
  );

  always @(negedge clk) begin
    cyc++;
    if (m_tvalid[0] && m_tready[0]) begin
      rx_q0.push_back({m_tlast[0], m_tkeep[0], m_tdata[0]});
      rx_cyc0.push_back(cyc);
    end
    if (m_tvalid[1] && m_tready[1]) rx_q1.push_back({m_tlast[1], m_tkeep[1], m_tdata[1]});
    for (int i = 0; i < 2; i++) begin
      if (drop[i])     drop_n[i]++;
      if (m_tvalid[i]) tv_seen[i] = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rx_size(input int idx);
    return (idx == 0) ? rx_q0.size() : rx_q1.size();
  endfunction

  task automatic rx_clear();
    rx_q0.delete();
    rx_q1.delete();
    rx_cyc0.delete();
  endtask

  // Drives one beat per cycle; returns the beat index of the first stall (-1 if none).
  task automatic send_pkt(input int idx, input int len, input int base, input bit user,
                          input bit fin, output int stall_at);
    bit acc;
    int budget;
    stall_at = -1;
    for (int b = 0; b < len; b++) begin
      s_tvalid[idx] = 1'b1;
      s_tdata[idx]  = 8'(base + b);
      s_tkeep[idx]  = 1'b1;
      s_tlast[idx]  = fin && (b == len - 1);
      s_tuser[idx]  = user && (b == len - 1);
      acc    = 1'b0;
      budget = 0;
      while (!acc && budget < 200) begin
        @(negedge clk);
        acc = s_tready[idx];
        if (!acc && stall_at < 0) stall_at = b;
        @(posedge clk); #1;
        budget++;
      end
      if (!acc) begin
        chk("send_timeout", acc, 1'b1);
        break;
      end
    end
    s_tvalid[idx] = 1'b0;
    s_tlast[idx]  = 1'b0;
    s_tuser[idx]  = 1'b0;
  endtask

  task automatic wait_rx(input int idx, input int n, input int budget);
    int c = 0;
    while (rx_size(idx) < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    chk($sformatf("rx_count%0d", idx), rx_size(idx), n);
  endtask

  task automatic chk_beats(input int idx, input int start, input int len, input int base, input string tag);
    logic [9:0] exp, got;
    for (int i = 0; i < len; i++) begin
      exp = {(i == len - 1), 1'b1, 8'(base + i)};
      got = '1;
      if (start + i < rx_size(idx)) got = (idx == 0) ? rx_q0[start + i] : rx_q1[start + i];
      chk($sformatf("%s[%0d]", tag, i), got, exp);
    end
  endtask

  initial begin
    int st;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
    st = 0;
  end

  initial begin
    int st;
    rst_n = 1'b0;
    clr = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0; m_tready = '0;
    s_tdata = '0; s_tkeep = '0;
    drop_n[0] = 0; drop_n[1] = 0;
    tv_seen[0] = 1'b0; tv_seen[1] = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", s_tready[0], 1'b0);
    chk("rst_m_tvalid", m_tvalid[0], 1'b0);
    chk("rst_m_tlast",  m_tlast[0],  1'b0);
    chk("rst_m_tdata",  m_tdata[0],  8'h00);
    chk("rst_m_tkeep",  m_tkeep[0],  1'b0);
    chk("rst_pkt_cnt",  pkt_cnt[0],  5'd0);
    chk("rst_free_big", free_big,    12'd2048);
    chk("rst_free_small", free_small, 5'd16);
    chk("rst_drop",     drop[0],     1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_s_tready", s_tready[0], 1'b1);
    @(posedge clk); #1;

    // Single 5-byte packet: latency N+2 and store-and-forward
    m_tready[0] = 1'b1;
    tv_seen[0]  = 1'b0;
    rx_clear();
    send_pkt(0, 5, 'h11, 1'b0, 1'b1, st);
    chk("p5_no_early_out", tv_seen[0], 1'b0);
    @(negedge clk);
    chk("p5_lat_n1_tvalid", m_tvalid[0], 1'b0);
    chk("p5_pkt_cnt_1", pkt_cnt[0], 5'd1);
    @(negedge clk);
    chk("p5_lat_n2_tvalid", m_tvalid[0], 1'b1);
    chk("p5_lat_n2_tdata", m_tdata[0], 8'h11);
    wait_rx(0, 5, 50);
    chk_beats(0, 0, 5, 'h11, "p5");
    @(negedge clk);
    chk("p5_pkt_cnt_0", pkt_cnt[0], 5'd0);
    chk("p5_free", free_big, 12'd2048);
    @(posedge clk); #1;

    // 16 back-to-back 4-word packets with output stalled, then drain
    m_tready[0] = 1'b0;
    rx_clear();
    for (int p = 0; p < 16; p++) begin
      send_pkt(0, 4, 'h20 + 4*p, 1'b0, 1'b1, st);
      chk($sformatf("b2b_stall_p%0d", p), st, -1);
    end
    @(negedge clk);
    chk("b2b_pkt_cnt_16", pkt_cnt[0], 5'd16);
    chk("b2b_hold_tvalid", m_tvalid[0], 1'b1);
    chk("b2b_hold_tdata", m_tdata[0], 8'h20);
    @(posedge clk); #1;
    s_tvalid[0] = 1'b1; s_tdata[0] = 8'hEE; s_tkeep[0] = 1'b1;
    @(negedge clk);
    chk("pkt17_s_tready", s_tready[0], 1'b0);
    @(posedge clk); #1;
    s_tvalid[0] = 1'b0;
    @(negedge clk);
    chk("b2b_hold_tdata2", m_tdata[0], 8'h20);
    chk("b2b_hold_tlast", m_tlast[0], 1'b0);
    @(posedge clk); #1;
    m_tready[0] = 1'b1;
    wait_rx(0, 64, 300);
    for (int p = 0; p < 16; p++) chk_beats(0, 4*p, 4, 'h20 + 4*p, $sformatf("b2b_p%0d", p));
    if (rx_cyc0.size() >= 64) chk("b2b_no_bubbles", rx_cyc0[63] - rx_cyc0[0], 63);
    @(negedge clk);
    chk("b2b_pkt_cnt_0", pkt_cnt[0], 5'd0);
    chk("b2b_free", free_big, 12'd2048);
    @(posedge clk); #1;

`ifdef ETH_PKT_FIFO_DROP_EN
    // Errored packet is dropped
    tv_seen[0] = 1'b0;
    drop_n[0]  = 0;
    rx_clear();
    send_pkt(0, 3, 'h70, 1'b1, 1'b1, st);
    repeat (4) @(negedge clk);
    chk("err_drop_pulses", drop_n[0], 1);
    chk("err_pkt_cnt", pkt_cnt[0], 5'd0);
    chk("err_free", free_big, 12'd2048);
    chk("err_no_tvalid", tv_seen[0], 1'b0);
    @(posedge clk); #1;

    // Oversize packet dropped, following packet intact
    m_tready[1] = 1'b1;
    drop_n[1]   = 0;
    send_pkt(1, 20, 'h80, 1'b0, 1'b1, st);
    chk("ovs_drop_stall", st, -1);
    repeat (4) @(negedge clk);
    chk("ovs_drop_pulses", drop_n[1], 1);
    chk("ovs_rx_empty", rx_q1.size(), 0);
    chk("ovs_free", free_small, 5'd16);
    @(posedge clk); #1;
    send_pkt(1, 4, 'hC0, 1'b0, 1'b1, st);
    wait_rx(1, 4, 50);
    chk_beats(1, 0, 4, 'hC0, "after_ovs");
    @(posedge clk); #1;
`else
    // Oversize packet with back-pressure, output draining
    m_tready[1] = 1'b1;
    rx_clear();
    send_pkt(1, 20, 'h40, 1'b0, 1'b1, st);
    chk("ovs_stall_at", st, 16);
    wait_rx(1, 20, 200);
    chk_beats(1, 0, 20, 'h40, "ovs");
    @(negedge clk);
    chk("ovs_pkt_cnt", pkt_cnt[1], 5'd0);
    chk("ovs_free", free_small, 5'd16);
    chk("ovs_drop", drop[1], 1'b0);
    @(posedge clk); #1;
`endif

    // Clear with 2 stored packets
    m_tready[0] = 1'b0;
    rx_clear();
    send_pkt(0, 3, 'h90, 1'b0, 1'b1, st);
    send_pkt(0, 3, 'hA0, 1'b0, 1'b1, st);
    @(negedge clk);
    chk("clr_pre_pkt_cnt", pkt_cnt[0], 5'd2);
    @(posedge clk); #1;
    clr[0] = 1'b1;
    @(negedge clk);
    chk("clr_s_tready", s_tready[0], 1'b0);
    chk("clr_m_tvalid", m_tvalid[0], 1'b0);
    @(posedge clk); #1;
    clr[0] = 1'b0;
    @(negedge clk);
    chk("clr_pkt_cnt", pkt_cnt[0], 5'd0);
    chk("clr_free", free_big, 12'd2048);
    chk("clr_m_tvalid_after", m_tvalid[0], 1'b0);
    chk("clr_drop", drop[0], 1'b0);
    @(posedge clk); #1;

    // Reset in the middle of a packet
    send_pkt(0, 2, 'hB0, 1'b0, 1'b0, st);
    rst_n = 1'b0;
    #2;
    chk("mrst_s_tready", s_tready[0], 1'b0);
    chk("mrst_m_tvalid", m_tvalid[0], 1'b0);
    chk("mrst_m_tdata", m_tdata[0], 8'h00);
    chk("mrst_pkt_cnt", pkt_cnt[0], 5'd0);
    chk("mrst_free", free_big, 12'd2048);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_tready[0] = 1'b1;
    rx_clear();
    send_pkt(0, 4, 'hD0, 1'b0, 1'b1, st);
    wait_rx(0, 4, 50);
    chk_beats(0, 0, 4, 'hD0, "post_rst");
    @(negedge clk);
    chk("post_rst_pkt_cnt", pkt_cnt[0], 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
